tl_request_unit: RTL and testbench

Front-end for the four-way traffic light controller's pedestrian and emergency inputs. Synchronises and debounces the raw push-buttons and presents them to the controller as held request levels (pd_button, em_button). Detects service from the controller's colour output, drives the walk indication and countdown during the all-red phase, and then enforces a hold-off before accepting new pedestrian requests.

---
 rtl/tl_request_unit.sv | 170 +++++++++++++++++
 tb/tb_tl_request_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_request_unit.sv
// Pedestrian/emergency request front-end for the four-way traffic light controller.
// Synchronises and debounces the buttons, holds requests until served, then runs walk and hold-off.
module tl_request_unit #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int WALK_CYC     = 10,
   parameter int HOLDOFF_CYC  = 20,
   parameter int TIMEOUT_CYC  = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_raw,
   input  logic       em_raw,
   input  logic [2:0] ctrl_color,
   output logic       pd_button,
   output logic       em_button,
   output logic       ped_walk,
   output logic       em_active,
   output logic [7:0] walk_remaining,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [7:0] DebLim  = 8'(DEBOUNCE_CYC);
   localparam logic [7:0] WalkLen = 8'(WALK_CYC);
   localparam logic [7:0] HoldLast = 8'(HOLDOFF_CYC - 1);
   localparam logic [7:0] TmoLim  = 8'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, REQ, SERVE, HOLDOFF} state_t;

   logic [1:0] sync1_q, sync2_q, press_q;
   logic [7:0] debCnt_q [2];
   logic [2:0] prevColor_q;
   state_t     state_q, state_d;
   logic       pedLat_q, pedLat_d, emLat_q, emLat_d, emPend_q, emPend_d;
   logic       timeout_q, timeout_d;
   logic [7:0] waitCnt_q, waitCnt_d, holdCnt_q, holdCnt_d, walkRem_q, walkRem_d;
   logic       pdButton_q, emButton_q, pedWalk_q, emActive_q, busy_q;
   logic       pedPress, emPress, serviceEvt;

   // Index 0 is the pedestrian button, index 1 the emergency button.
   // The counter saturates at the limit so a held button pulses only once.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         press_q <= '0;
         for (int i = 0; i < 2; i++) debCnt_q[i] <= '0;
      end else begin
         sync1_q <= {em_raw, ped_raw};
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (!sync2_q[i])
               debCnt_q[i] <= '0;
            else if (debCnt_q[i] != DebLim)
               debCnt_q[i] <= debCnt_q[i] + 8'd1;
            press_q[i] <= sync2_q[i] && (debCnt_q[i] == DebLim - 8'd1);
         end
      end
   end

   assign pedPress   = press_q[0];
   assign emPress    = press_q[1];
   assign serviceEvt = (prevColor_q == 3'b010) && (ctrl_color == 3'b100);

   always_comb begin
      state_d   = state_q;
      pedLat_d  = pedLat_q;
      emLat_d   = emLat_q;
      emPend_d  = emPend_q;
      timeout_d = timeout_q;
      waitCnt_d = waitCnt_q;
      holdCnt_d = holdCnt_q;
      walkRem_d = walkRem_q;
      case (state_q)
         IDLE: begin
            if (pedPress || emPress) begin
               pedLat_d  = pedPress;
               emLat_d   = emPress;
               waitCnt_d = '0;
               state_d   = REQ;
            end
         end
         REQ: begin
            pedLat_d = pedLat_q | pedPress;
            emLat_d  = emLat_q | emPress;
            if (serviceEvt) begin
               state_d   = SERVE;
               walkRem_d = WalkLen;
               waitCnt_d = '0;
            end else begin
               if (waitCnt_q != TmoLim) waitCnt_d = waitCnt_q + 8'd1;
               if (waitCnt_d == TmoLim) timeout_d = 1'b1;
            end
         end
         SERVE: begin
            emPend_d = emPend_q | emPress;
            if (walkRem_q <= 8'd1) begin
               state_d   = HOLDOFF;
               walkRem_d = '0;
               pedLat_d  = 1'b0;
               emLat_d   = 1'b0;
               holdCnt_d = '0;
            end else begin
               walkRem_d = walkRem_q - 8'd1;
            end
         end
         HOLDOFF: begin
            emPend_d = emPend_q | emPress;
            if (holdCnt_q == HoldLast) begin
               holdCnt_d = '0;
               if (emPend_d) begin
                  state_d   = REQ;
                  emLat_d   = 1'b1;
                  emPend_d  = 1'b0;
                  waitCnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               holdCnt_d = holdCnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they change on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         prevColor_q <= '0;
         pedLat_q    <= 1'b0;
         emLat_q     <= 1'b0;
         emPend_q    <= 1'b0;
         timeout_q   <= 1'b0;
         waitCnt_q   <= '0;
         holdCnt_q   <= '0;
         walkRem_q   <= '0;
         pdButton_q  <= 1'b0;
         emButton_q  <= 1'b0;
         pedWalk_q   <= 1'b0;
         emActive_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prevColor_q <= ctrl_color;
         pedLat_q    <= pedLat_d;
         emLat_q     <= emLat_d;
         emPend_q    <= emPend_d;
         timeout_q   <= timeout_d;
         waitCnt_q   <= waitCnt_d;
         holdCnt_q   <= holdCnt_d;
         walkRem_q   <= walkRem_d;
         pdButton_q  <= (state_d == REQ) && pedLat_d;
         emButton_q  <= (state_d == REQ) && emLat_d;
         pedWalk_q   <= (state_d == SERVE) && pedLat_d;
         emActive_q  <= (state_d == SERVE) && emLat_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign pd_button      = pdButton_q;
   assign em_button      = emButton_q;
   assign ped_walk       = pedWalk_q;
   assign em_active      = emActive_q;
   assign walk_remaining = walkRem_q;
   assign busy           = busy_q;
   assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_tl_request_unit.sv
// Self-checking bench for tl_request_unit: directed scenarios plus random button/colour traffic,
// compared every cycle against a timestamp-based reference model.
module tb_tl_request_unit;

   localparam int D = 4, W = 10, H = 20, T = 200;
   localparam int M_IDLE = 0, M_REQ = 1, M_SERVE = 2, M_HOLD = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ped_raw = 1'b0, em_raw = 1'b0;
   logic [2:0] ctrl_color = 3'b001;
   logic       pd_button, em_button, ped_walk, em_active, busy, timeout_err;
   logic [7:0] walk_remaining;

   int testCount = 0;
   int failCount = 0;

   tl_request_unit #(
      .DEBOUNCE_CYC(D), .WALK_CYC(W), .HOLDOFF_CYC(H), .TIMEOUT_CYC(T)
   ) dut (
      .clk(clk), .reset(reset), .ped_raw(ped_raw), .em_raw(em_raw), .ctrl_color(ctrl_color),
      .pd_button(pd_button), .em_button(em_button), .ped_walk(ped_walk), .em_active(em_active),
      .walk_remaining(walk_remaining), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Reference model: phases tracked by entry timestamps, button runs by consecutive-sample counts.
   int   mMode = M_IDLE, mNow = 0, mReqStart = 0, mServeStart = 0, mHoldStart = 0;
   bit   mWantPed, mWantEm, mWalkPed, mWalkEm, mPend, mErr;
   int   pRun [3], eRun [3];
   bit   pPress, ePress;
   logic [2:0] mPrev;

   function automatic void modelEdge();
      bit pP, eP, svc;
      mNow++;
      if (!reset) begin
         mMode = M_IDLE; mWantPed = 0; mWantEm = 0; mWalkPed = 0; mWalkEm = 0;
         mPend = 0; mErr = 0; mPrev = 3'b000; pPress = 0; ePress = 0;
         for (int i = 0; i < 3; i++) begin pRun[i] = 0; eRun[i] = 0; end
         return;
      end
      pP  = pPress;
      eP  = ePress;
      svc = (mPrev == 3'b010) && (ctrl_color == 3'b100);
      case (mMode)
         M_IDLE: if (pP || eP) begin
            mMode = M_REQ; mWantPed = pP; mWantEm = eP; mReqStart = mNow;
         end
         M_REQ: begin
            mWantPed |= pP; mWantEm |= eP;
            if (svc) begin
               mMode = M_SERVE; mServeStart = mNow; mWalkPed = mWantPed; mWalkEm = mWantEm;
            end else if (mNow - mReqStart >= T) mErr = 1;
         end
         M_SERVE: begin
            mPend |= eP;
            if (mNow - mServeStart == W) begin
               mMode = M_HOLD; mHoldStart = mNow; mWantPed = 0; mWantEm = 0;
            end
         end
         default: begin
            mPend |= eP;
            if (mNow - mHoldStart == H) begin
               if (mPend) begin
                  mMode = M_REQ; mWantEm = 1; mWantPed = 0; mPend = 0; mReqStart = mNow;
               end else mMode = M_IDLE;
            end
         end
      endcase
      mPrev = ctrl_color;
      pRun[2] = pRun[1]; pRun[1] = pRun[0]; pRun[0] = ped_raw ? ((pRun[0] < 255) ? pRun[0] + 1 : 255) : 0;
      eRun[2] = eRun[1]; eRun[1] = eRun[0]; eRun[0] = em_raw ? ((eRun[0] < 255) ? eRun[0] + 1 : 255) : 0;
      pPress = (pRun[2] == D);
      ePress = (eRun[2] == D);
   endfunction

   task automatic checkInt(string tag, int obs, int exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkInt("pd_button", int'(pd_button), int'(mMode == M_REQ && mWantPed));
      checkInt("em_button", int'(em_button), int'(mMode == M_REQ && mWantEm));
      checkInt("ped_walk", int'(ped_walk), int'(mMode == M_SERVE && mWalkPed));
      checkInt("em_active", int'(em_active), int'(mMode == M_SERVE && mWalkEm));
      checkInt("walk_remaining", int'(walk_remaining), (mMode == M_SERVE) ? W - (mNow - mServeStart) : 0);
      checkInt("busy", int'(busy), int'(mMode != M_IDLE));
      checkInt("timeout_err", int'(timeout_err), int'(mErr));
   endtask

   // Advance n clock cycles, updating the model at each rising edge and checking at the falling edge.
   task automatic applyStimulus(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         modelEdge();
         @(negedge clk);
         checkOutput();
      end
   endtask

   task automatic pressButtons(bit p, bit e, int len);
      ped_raw = p; em_raw = e;
      applyStimulus(len);
      ped_raw = 0; em_raw = 0;
   endtask

   task automatic serviceSeq();
      ctrl_color = 3'b010;
      applyStimulus($urandom_range(1, 3));
      ctrl_color = 3'b100;
      applyStimulus(1);
   endtask

   initial begin
      int riseAt, found, colorTimer;

      // Reset held with the pedestrian button pressed, then released.
      ped_raw = 1; reset = 0;
      applyStimulus(3);
      reset = 1;
      riseAt = -1;
      for (int k = 1; k <= 20 && riseAt < 0; k++) begin
         applyStimulus(1);
         if (pd_button) riseAt = k;
      end
      checkInt("pd_latency_after_reset", riseAt, D + 3);
      ped_raw = 0;
      applyStimulus($urandom_range(2, 6));
      serviceSeq();
      checkInt("walk_start", int'(walk_remaining), W);
      ctrl_color = 3'b001;
      applyStimulus(W + H + 2);
      checkInt("idle_after_ped_service", int'(busy), 0);

      // Glitch shorter than the debounce window.
      pressButtons(1, 0, D - 1);
      applyStimulus(12);
      checkInt("glitch_busy", int'(busy), 0);

      // Simultaneous press of both buttons.
      pressButtons(1, 1, $urandom_range(D + 1, D + 5));
      applyStimulus(4);
      checkInt("both_em_button", int'(em_button), 1);
      serviceSeq();
      checkInt("both_em_active", int'(em_active), 1);
      ctrl_color = 3'b001;
      applyStimulus(W + H + 2);

      // Emergency press during SERVE, pedestrian press during HOLDOFF.
      pressButtons(1, 0, D + 2);
      applyStimulus(4);
      serviceSeq();
      ctrl_color = 3'b001;
      applyStimulus(1);
      pressButtons(0, 1, D + 2);
      applyStimulus(W);
      pressButtons(1, 0, D + 2);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         applyStimulus(1);
         if (em_button) found = 1;
      end
      checkInt("em_pending_served", found, 1);
      checkInt("ped_in_holdoff_dropped", int'(pd_button), 0);
      serviceSeq();
      ctrl_color = 3'b001;
      applyStimulus(W + H + 2);

      // Random button and colour traffic.
      colorTimer = $urandom_range(1, 15);
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 5) == 0) ped_raw = ~ped_raw;
         if ($urandom_range(0, 11) == 0) em_raw = ~em_raw;
         colorTimer--;
         if (colorTimer == 0) begin
            colorTimer = $urandom_range(1, 15);
            case (ctrl_color)
               3'b001:  ctrl_color = 3'b010;
               3'b010:  ctrl_color = 3'b100;
               default: ctrl_color = 3'b001;
            endcase
         end
         applyStimulus(1);
      end
      ped_raw = 0; em_raw = 0; ctrl_color = 3'b001;
      reset = 0;
      applyStimulus(1);
      reset = 1;
      applyStimulus(2);

      // Timeout with the controller stuck on green, then a mid-operation reset.
      pressButtons(1, 0, D + 2);
      applyStimulus(T + 5);
      checkInt("timeout_set", int'(timeout_err), 1);
      checkInt("timeout_pd_held", int'(pd_button), 1);
      reset = 0;
      applyStimulus(1);
      reset = 1;
      checkInt("reset_clears_timeout", int'(timeout_err), 0);
      checkInt("reset_clears_busy", int'(busy), 0);
      applyStimulus(3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
